stereo_decoder_48: RTL and testbench
====================================

Name: stereo_decoder_48

Overview:
Receive-side counterpart of the stereo encoder. Takes the scaled sum and difference channels (LpR, LmR) once per 48 kHz enable and reconstructs left = (LpR+LmR)/2 and right = (LpR-LmR)/2. Each reconstructed channel is then scaled by its own 4-bit gain (K/16). Multiplication uses a shared-timing sequential shift-add multiplier pair, so one sample takes several clocks inside the 48 kHz frame.

Parameters:
W, 18, sample width (signed) of inputs and outputs
KW, 4, gain width (unsigned, value K/16)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enableclk48  in  1  one-clock strobe at 48 kHz; starts a conversion
LpR_in  in  W  signed sum channel
LmR_in  in  W  signed difference channel
Kl  in  KW  left gain, unsigned, scale Kl/16
Kr  in  KW  right gain, unsigned, scale Kr/16
left_out  out  W  signed reconstructed left
right_out  out  W  signed reconstructed right
ready  out  1  one-clock pulse, outputs updated
busy  out  1  high from LOAD through DONE

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; left_out=0, right_out=0, ready=0, busy=0.
  - Internal accumulators and counter are cleared.
- FSM states IDLE, LOAD, MULT, DONE.
  - IDLE: on enableclk48=1, latch LpR_in, LmR_in, Kl, Kr, then go to LOAD.
  - LOAD: sum = LpR+LmR and diff = LpR-LmR, each W+1 bits signed, no overflow possible. Multiplicands are {1'b0,Kl} and {1'b0,Kr}, KW+1 bits. Clear products and set iteration counter=0. Go to MULT.
  - MULT: exactly KW+1 = 5 iterations, one per clock. Each iteration conditionally adds the sign-extended shifted multiplicand, LSB first. After iteration 5, go to DONE.
  - DONE: register the outputs, pulse ready for one clock, return to IDLE.
- Latency: enableclk48 sampled high on edge 0. ready=1 and new outputs are visible after edge 7 and held for one clock. Outputs hold their values until the next DONE.
- Arithmetic:
  - Products are W+KW+2 = 24 bits signed.
  - left_out = prodL[22:5] and right_out = prodR[22:5]. This is arithmetic >>5 (/2 for reconstruction, /16 for gain), truncating toward -inf.
  - Result always fits in W bits, so no saturation is needed in the base build.
- Boundaries:
  - K=0 gives output 0.
  - enableclk48 while busy=1 is ignored; no queueing.
  - enableclk48 on the same edge as DONE is ignored, because IDLE is re-entered only on the next edge.
  - Inputs changing after latch do not affect the current result.
  - reset mid-conversion aborts immediately: no ready pulse, outputs forced to 0.
  - reset and enableclk48 on the same edge: reset wins.

Optional Feature:
STEREO_DEC_ROUND_EN.
- Defined: add 2^4 to each product before the >>5 (round half up). If the rounded result exceeds 2^(W-1)-1, saturate to 131071; the negative side cannot overflow. Latency is unchanged.
- Undefined: plain truncation as above.

Decomposition:
- Shared package stereo_pkg holds:
  - W and KW defaults
  - state encoding (typedef, 2 bits)
  - the shift constant 5 and the rounding constant 16
  - the 48 kHz divider constant already used by the encoder side
- One natural sub-module: stereo_dec_mac, a single-channel W+1 x KW+1 shift-add multiplier with start/iteration inputs. It is instantiated twice (left, right) and sequenced by the parent FSM, so the counter is shared.

Test Plan:
- reset held 3 clocks, then released -> left_out=0, right_out=0, ready=0, busy=0.
- LpR=1000, LmR=200, Kl=Kr=15, strobe -> ready exactly 7 clocks later, left_out=562, right_out=375. With STEREO_DEC_ROUND_EN: 563 and 375.
- LpR=-1000, LmR=-200, Kl=Kr=8 -> left_out=-300, right_out=-200. Then Kl=0, Kr=15, LpR=500, LmR=100 -> left_out=0, right_out=187.
- LpR=LmR=131071, Kl=15 -> left_out=122879, right_out=0.
- Strobe at edge 0, second strobe at edge 3 -> only one ready pulse (edge 7), and the second set of inputs is not processed.
- Strobe, then reset asserted at edge 4 for 1 clock -> no ready pulse, outputs 0, busy 0. A next strobe then converts normally.

Source files
------------

// File: rtl/stereo_pkg.sv
// stereo_pkg: shared definitions for the stereo encoder/decoder pair.
//   W_DEF / KW_DEF  : default sample width and gain width
//   state_t + ST_*  : 2-bit decoder FSM encoding
//   SHIFT / RND_ADD : output shift (/2 reconstruction, /16 gain) and rounding offset
//   CLK_DIV_48K     : 48 kHz strobe divider used by the encoder side (50 MHz clock)
package stereo_pkg;

    localparam int W_DEF   = 18;
    localparam int KW_DEF  = 4;

    localparam int SHIFT   = 5;
    localparam int RND_ADD = 16;

    localparam int CLK_DIV_48K = 1042;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_MULT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/stereo_dec_mac.sv
// stereo_dec_mac: single-channel (W+1) x (KW+1) shift-add multiplier.
// Sequenced externally: load captures operands and clears the product,
// each step adds the shifted multiplicand when multiplier bit 'iter' is set.
//   clock, reset : clock, synchronous active-high reset
//   load         : capture a/b, clear prod
//   step         : perform one iteration at bit index iter
//   iter         : iteration index (LSB first), shared by both channels
//   a            : signed multiplicand (sum or difference)
//   b            : unsigned multiplier {1'b0, K}
//   prod         : signed product, W+KW+2 bits
module stereo_dec_mac #(
    parameter int W  = 18,
    parameter int KW = 4,
    parameter int CW = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    step,
    input  logic [CW-1:0]           iter,
    input  logic signed [W:0]       a,
    input  logic [KW:0]             b,
    output logic signed [W+KW+1:0]  prod
);

    localparam int PW = W + KW + 2;

    logic signed [W:0]    a_r;
    logic [KW:0]          b_r;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] addend;

    // Multiplier MSB is always 0, so every partial product is an add.
    assign a_ext  = {{(KW+1){a_r[W]}}, a_r};
    assign addend = a_ext <<< iter;

    always_ff @(posedge clock) begin
        if (reset) begin
            a_r  <= '0;
            b_r  <= '0;
            prod <= '0;
        end else if (load) begin
            a_r  <= a;
            b_r  <= b;
            prod <= '0;
        end else if (step && b_r[iter]) begin
            prod <= prod + addend;
        end
    end

endmodule

// File: rtl/stereo_decoder_48.sv
// stereo_decoder_48: rebuilds left/right from sum/difference channels and
// applies per-channel gain K/16, once per 48 kHz strobe.
//   left  = ((LpR+LmR) * Kl) >>> 5,  right = ((LpR-LmR) * Kr) >>> 5
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   enableclk48         : strobe; starts a conversion when idle
//   LpR_in, LmR_in      : signed sum / difference inputs (W bits)
//   Kl, Kr              : unsigned gains (KW bits, scale K/16)
//   left_out, right_out : signed reconstructed outputs, held until next result
//   ready               : one-clock pulse when outputs update
//   busy                : high from LOAD through DONE
// Build option: define STEREO_DEC_ROUND_EN for round-half-up with positive
// saturation instead of truncation.
module stereo_decoder_48
    import stereo_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int KW = KW_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enableclk48,
    input  logic signed [W-1:0] LpR_in,
    input  logic signed [W-1:0] LmR_in,
    input  logic [KW-1:0]       Kl,
    input  logic [KW-1:0]       Kr,
    output logic signed [W-1:0] left_out,
    output logic signed [W-1:0] right_out,
    output logic                ready,
    output logic                busy
);

    localparam int PW   = W + KW + 2;
    localparam int CW   = $clog2(KW + 1);
    localparam int MAXP = 2**(W-1) - 1;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic signed [W-1:0]  lpr_r;
    logic signed [W-1:0]  lmr_r;
    logic [KW-1:0]        kl_r;
    logic [KW-1:0]        kr_r;

    logic signed [W:0]    sum_c;
    logic signed [W:0]    diff_c;
    logic                 mac_load;
    logic                 mac_step;
    logic signed [PW-1:0] prod_l;
    logic signed [PW-1:0] prod_r;

    // Product to output sample: drop the combined /2 and /16 scale.
    function automatic logic signed [W-1:0] scale_out(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] t;
`ifdef STEREO_DEC_ROUND_EN
        t = (p + PW'(RND_ADD)) >>> SHIFT;
        if (t > PW'(MAXP))
            t = PW'(MAXP);
`else
        t = p >>> SHIFT;
`endif
        return t[W-1:0];
    endfunction

    // W+1 bits holds any sum/difference of two W-bit values.
    assign sum_c  = {lpr_r[W-1], lpr_r} + {lmr_r[W-1], lmr_r};
    assign diff_c = {lpr_r[W-1], lpr_r} - {lmr_r[W-1], lmr_r};

    assign mac_load = (state == ST_LOAD);
    assign mac_step = (state == ST_MULT);
    assign busy     = (state != ST_IDLE);

    stereo_dec_mac #(.W(W), .KW(KW), .CW(CW)) u_mac_l (
        .clock (clock),
        .reset (reset),
        .load  (mac_load),
        .step  (mac_step),
        .iter  (cnt),
        .a     (sum_c),
        .b     ({1'b0, kl_r}),
        .prod  (prod_l)
    );

    stereo_dec_mac #(.W(W), .KW(KW), .CW(CW)) u_mac_r (
        .clock (clock),
        .reset (reset),
        .load  (mac_load),
        .step  (mac_step),
        .iter  (cnt),
        .a     (diff_c),
        .b     ({1'b0, kr_r}),
        .prod  (prod_r)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lpr_r     <= '0;
            lmr_r     <= '0;
            kl_r      <= '0;
            kr_r      <= '0;
            left_out  <= '0;
            right_out <= '0;
            ready     <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                // Capture inputs; later input changes cannot disturb this result.
                ST_IDLE: begin
                    if (enableclk48) begin
                        lpr_r <= LpR_in;
                        lmr_r <= LmR_in;
                        kl_r  <= Kl;
                        kr_r  <= Kr;
                        state <= ST_LOAD;
                    end
                end
                // MACs capture sum/diff and clear their products here.
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_MULT;
                end
                // KW+1 iterations, one multiplier bit per clock.
                ST_MULT: begin
                    if (cnt == CW'(KW))
                        state <= ST_DONE;
                    else
                        cnt <= cnt + 1'b1;
                end
                // Publish results; a strobe here is dropped since IDLE comes next edge.
                ST_DONE: begin
                    left_out  <= scale_out(prod_l);
                    right_out <= scale_out(prod_r);
                    ready     <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stereo_decoder_48.sv
module tb_stereo_decoder_48;

    logic               clock = 1'b0;
    logic               reset;
    logic               enableclk48;
    logic signed [17:0] LpR_in;
    logic signed [17:0] LmR_in;
    logic [3:0]         Kl;
    logic [3:0]         Kr;
    logic signed [17:0] left_out;
    logic signed [17:0] right_out;
    logic               ready;
    logic               busy;

    typedef struct {
        int l;
        int r;
    } exp_t;

    exp_t sb[$];
    int   errors    = 0;
    int   checks    = 0;
    int   ready_cnt = 0;

    stereo_decoder_48 dut (
        .clock       (clock),
        .reset       (reset),
        .enableclk48 (enableclk48),
        .LpR_in      (LpR_in),
        .LmR_in      (LmR_in),
        .Kl          (Kl),
        .Kr          (Kr),
        .left_out    (left_out),
        .right_out   (right_out),
        .ready       (ready),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: (a+b)*k scaled by 1/32, with optional round/saturate.
    function automatic int model(input int a, input int b, input int k);
        int p;
        p = (a + b) * k;
`ifdef STEREO_DEC_ROUND_EN
        p = p + 16;
`endif
        p = p >>> 5;
`ifdef STEREO_DEC_ROUND_EN
        if (p > 131071) p = 131071;
`endif
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        if (ready) ready_cnt++;
    endtask

    task automatic wait_ready(input string tag, input int n0);
        int   n;
        exp_t e;
        n = n0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, n, 7);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (ready) begin
                check_eq({tag, "_left"}, left_out, e.l);
                check_eq({tag, "_right"}, right_out, e.r);
            end
        end else begin
            check_eq({tag, "_sb_empty"}, 1, 0);
        end
        tick();
        check_eq({tag, "_ready_pulse"}, ready, 0);
        check_eq({tag, "_busy_after"}, busy, 0);
        if (sb.size() == 0) begin
            check_eq({tag, "_left_hold"}, left_out, e.l);
        end
    endtask

    task automatic start(input int a, input int b, input int kl, input int kr, input bit push);
        exp_t e;
        LpR_in      = 18'(a);
        LmR_in      = 18'(b);
        Kl          = 4'(kl);
        Kr          = 4'(kr);
        enableclk48 = 1'b1;
        if (push) begin
            e.l = model(a, b, kl);
            e.r = model(a, -b, kr);
            sb.push_back(e);
        end
        tick();
        enableclk48 = 1'b0;
        // Scramble inputs to show they were latched.
        LpR_in = 18'($urandom);
        LmR_in = 18'($urandom);
        Kl     = 4'($urandom);
        Kr     = 4'($urandom);
    endtask

    task automatic convert(input string tag, input int a, input int b, input int kl, input int kr);
        start(a, b, kl, kr, 1'b1);
        check_eq({tag, "_busy"}, busy, 1);
        wait_ready(tag, 0);
    endtask

    initial begin
        int r0;
        reset       = 1'b1;
        enableclk48 = 1'b0;
        LpR_in      = '0;
        LmR_in      = '0;
        Kl          = '0;
        Kr          = '0;

        // Reset for 3 clocks; strobe on the last reset edge must lose.
        tick();
        tick();
        enableclk48 = 1'b1;
        LpR_in      = 18'(1000);
        Kl          = 4'(15);
        tick();
        reset       = 1'b0;
        enableclk48 = 1'b0;
        check_eq("rst_left", left_out, 0);
        check_eq("rst_right", right_out, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_busy", busy, 0);
        tick();
        tick();
        check_eq("rst_strobe_ignored", busy, 0);

        convert("basic", 1000, 200, 15, 15);
        convert("neg", -1000, -200, 8, 8);
        convert("kzero", 500, 100, 0, 15);
        convert("maxpos", 131071, 131071, 15, 15);
        convert("minneg", -131072, -131072, 15, 15);
        convert("mixed", -131072, 131071, 15, 7);
        for (int i = 0; i < 4; i++) begin
            convert("rand", $signed(18'($urandom)), $signed(18'($urandom)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        // Second strobe while busy is dropped.
        r0 = ready_cnt;
        start(700, -300, 9, 5, 1'b1);
        tick();
        tick();
        LpR_in      = 18'(-5000);
        LmR_in      = 18'(4000);
        Kl          = 4'(3);
        Kr          = 4'(11);
        enableclk48 = 1'b1;
        tick();
        enableclk48 = 1'b0;
        wait_ready("dbl", 3);
        for (int i = 0; i < 12; i++) tick();
        check_eq("dbl_pulses", ready_cnt - r0, 1);
        check_eq("dbl_busy", busy, 0);

        // Reset at edge 4 aborts the conversion.
        r0 = ready_cnt;
        start(1000, 200, 15, 15, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_left", left_out, 0);
        check_eq("abort_right", right_out, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", ready, 0);
        for (int i = 0; i < 12; i++) tick();
        check_eq("abort_no_pulse", ready_cnt - r0, 0);

        convert("after_abort", 1000, 200, 15, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
